// File: rtl/data_memory_pkg.sv
// Shared datapath constants and types for the load/store side of the core.
package data_memory_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef logic [DATA_W-1:0] word_t;

endpackage : data_memory_pkg

// File: rtl/data_memory.sv
// Word-addressed data RAM: clocked full-word writes, combinational reads,
// asynchronous active-low clear of every word.
module data_memory #(
  parameter int DATA_W = data_memory_pkg::DATA_W,
  parameter int ADDR_W = data_memory_pkg::ADDR_W,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  import data_memory_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("data_memory: DEPTH must be a power of two and at least 2");
  end

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] word_q [DEPTH];
  logic [DATA_W-1:0] word_d [DEPTH];

  // Byte-offset bits and bits above the index field are deliberately dropped,
  // so unaligned accesses hit the containing word and addresses alias.
  assign idx = a[2 +: IDX_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{a[1:0], a[ADDR_W-1:2+IDX_W]};

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    always_comb begin
      word_d[gi] = word_q[gi];
      // An unknown we falls through to the hold value, i.e. no write.
      if (we && (idx == IDX_W'(gi))) begin
        word_d[gi] = wd;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_q[gi] <= '0;
      end else begin
        word_q[gi] <= word_d[gi];
      end
    end
  end

  assign rd = word_q[idx];

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus random traffic
// compared against an address-arithmetic reference model.
module tb_data_memory;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [DEPTH];

  data_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic int widx(input logic [31:0] addr);
    return int'((addr / 32'd4) % DEPTH);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // One write cycle: drive on the falling edge, commit on the rising edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    a  = addr;
    wd = data;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    model[widx(addr)] = data;
    $display("write a=%0d wd=%0d -> word %0d", addr, data, widx(addr));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    we    = 1'b0;
    a     = '0;
    wd    = '0;
    repeat (2) @(posedge clk);
    model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      a = 32'(i * 4);
      #1;
      checks++;
      if (rd !== model[i]) begin
        failures++;
        $display("FAIL reset_sweep a=%0d actual=%h required=%h", a, rd, model[i]);
      end
    end
    $display("reset: swept %0d words", DEPTH);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_write(32'd0, 32'd1);
    a = 32'd0; #1;
    checks++;
    if (rd !== 32'd1) begin
      failures++;
      $display("FAIL basic_read a=0 actual=%0d required=1", rd);
    end
    a = 32'd4; #1;
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL basic_neighbour a=4 actual=%0d required=0", rd);
    end
    $display("basic: read a=0 and a=4");
  endtask

  task automatic test_distant();
    do_write(32'd100, 32'd66);
    a = 32'd100; #1;
    checks++;
    if (rd !== 32'd66) begin
      failures++;
      $display("FAIL distant_read a=100 actual=%0d required=66", rd);
    end
    a = 32'd0; #1;
    checks++;
    if (rd !== 32'd1) begin
      failures++;
      $display("FAIL distant_keep a=0 actual=%0d required=1", rd);
    end
    $display("distant: word 25 written, word 0 preserved");
  endtask

  task automatic test_unaligned();
    do_write(32'd1, 32'd77);
    for (int i = 0; i < 4; i++) begin
      a = 32'(i); #1;
      checks++;
      if (rd !== 32'd77) begin
        failures++;
        $display("FAIL unaligned_read a=%0d actual=%0d required=77", a, rd);
      end
    end
    a = 32'd100; #1;
    checks++;
    if (rd !== 32'd66) begin
      failures++;
      $display("FAIL unaligned_keep a=100 actual=%0d required=66", rd);
    end
    $display("unaligned: a=0..3 read word 0");
  endtask

  task automatic test_write_disable();
    @(negedge clk);
    a  = 32'd100;
    wd = 32'd5;
    we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rd !== 32'd66) begin
      failures++;
      $display("FAIL we_low a=100 actual=%0d required=66", rd);
    end
    a = 32'd356; #1;
    checks++;
    if (rd !== 32'd66) begin
      failures++;
      $display("FAIL upper_alias a=356 actual=%0d required=66", rd);
    end
    a = 32'd256; #1;
    checks++;
    if (rd !== 32'd77) begin
      failures++;
      $display("FAIL upper_alias a=256 actual=%0d required=77", rd);
    end
    $display("write_disable: no change over 3 edges, aliases read");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    a     = 32'd0;
    we    = 1'b1;
    wd    = 32'd9;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL async_clear a=0 actual=%0d required=0", rd);
    end
    a = 32'd100; #1;
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL async_clear a=100 actual=%0d required=0", rd);
    end
    a = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL write_in_reset a=0 actual=%0d required=0", rd);
    end
    // Release between edges with the write still pending.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL pre_edge_after_release a=0 actual=%0d required=0", rd);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    model[0] = 32'd9;
    checks++;
    if (rd !== 32'd9) begin
      failures++;
      $display("FAIL first_write_after_release a=0 actual=%0d required=9", rd);
    end
    $display("async_reset: cleared immediately, writes blocked, first write landed");
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [31:0] rdata;
    logic        rwe;
    for (int n = 0; n < 300; n++) begin
      ra    = $urandom();
      if (n % 3 == 0) ra = ra & 32'h0000_00ff;
      rdata = $urandom();
      rwe   = 1'($urandom_range(0, 1));
      @(negedge clk);
      a  = ra;
      wd = rdata;
      we = rwe;
      #1;
      checks++;
      if (rd !== model[widx(ra)]) begin
        failures++;
        $display("FAIL rand_pre_edge a=%h actual=%h required=%h", ra, rd, model[widx(ra)]);
      end
      @(posedge clk);
      #1;
      if (rwe) model[widx(ra)] = rdata;
      checks++;
      if (rd !== model[widx(ra)]) begin
        failures++;
        $display("FAIL rand_post_edge a=%h we=%0d actual=%h required=%h", ra, rwe, rd, model[widx(ra)]);
      end
      $display("rand %0d: a=%h we=%0d wd=%h rd=%h", n, ra, rwe, rdata, rd);
    end
    we = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      a = 32'(i * 4) + 32'($urandom_range(0, 3)) + (32'($urandom_range(0, 255)) << 8);
      #1;
      checks++;
      if (rd !== model[i]) begin
        failures++;
        $display("FAIL rand_sweep a=%h actual=%h required=%h", a, rd, model[i]);
      end
    end
    $display("random: final sweep of %0d words", DEPTH);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_distant();
    test_unaligned();
    test_write_disable();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_data_memory
